// File: rtl/ctl_shot.sv
// rtl/ctl_shot.sv - shot arbitration, hit test, ammo/cooldown and score keeping
module ctl_shot #(
    parameter int DUCK_W          = 64,
    parameter int DUCK_H          = 64,
    parameter int AMMO_MAX        = 3,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int HIT_POINTS      = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic        round_start,
    input  logic        trigger,
    input  logic [10:0] aim_x,
    input  logic [10:0] aim_y,
    input  logic [10:0] duck_x,
    input  logic [10:0] duck_y,
    input  logic        duck_show,
    output logic        shot_fired,
    output logic        duck_hit_evt,
    output logic [1:0]  ammo,
    output logic [3:0]  hits,
    output logic [15:0] score,
    output logic        round_over
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READY    = 2'd1,
        COOLDOWN = 2'd2,
        EMPTY    = 2'd3
    } state_t;

    localparam logic [1:0]  AMMO_LOAD = 2'(AMMO_MAX);
    localparam logic [5:0]  CD_LOAD   = 6'(COOLDOWN_FRAMES);
    localparam logic [11:0] BOX_W     = 12'(DUCK_W);
    localparam logic [11:0] BOX_H     = 12'(DUCK_H);
    localparam logic [16:0] PTS       = 17'(HIT_POINTS);

    state_t      state, state_n;
    logic        trigger_q;
    logic        hit_lock, hit_lock_n;
    logic [5:0]  cd_cnt, cd_cnt_n;
    logic [1:0]  ammo_n;
    logic [3:0]  hits_n;
    logic [15:0] score_n;
    logic        shot_n, hit_evt_n;

    logic        trig_edge;
    logic        in_x, in_y, hit;
    logic [11:0] ax, ay, dx, dy;
    logic [16:0] score_sum;

    // One extra bit keeps duck_x + DUCK_W from wrapping near the screen edge
    always_comb begin
        ax = {1'b0, aim_x};
        ay = {1'b0, aim_y};
        dx = {1'b0, duck_x};
        dy = {1'b0, duck_y};
        in_x = (ax >= dx) && (ax < dx + BOX_W);
        in_y = (ay >= dy) && (ay < dy + BOX_H);
        hit  = duck_show && in_x && in_y && !hit_lock;
    end

    assign trig_edge = trigger & ~trigger_q;
    assign score_sum = {1'b0, score} + PTS;

    always_comb begin
        state_n    = state;
        ammo_n     = ammo;
        hits_n     = hits;
        score_n    = score;
        cd_cnt_n   = cd_cnt;
        shot_n     = 1'b0;
        hit_evt_n  = 1'b0;
        hit_lock_n = duck_show ? hit_lock : 1'b0;

        // round_start overrides everything, including a same-cycle trigger edge
        if (round_start) begin
            state_n  = READY;
            ammo_n   = AMMO_LOAD;
            hits_n   = 4'd0;
            cd_cnt_n = 6'd0;
        end else begin
            case (state)
                READY: begin
                    if (trig_edge) begin
                        shot_n   = 1'b1;
                        ammo_n   = ammo - 2'd1;
                        cd_cnt_n = CD_LOAD;
                        state_n  = COOLDOWN;
                        if (hit) begin
                            hit_evt_n  = 1'b1;
                            hit_lock_n = 1'b1;
                            hits_n     = (hits == 4'hF) ? 4'hF : hits + 4'd1;
                            score_n    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        end
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == 6'd0 || (new_frame && cd_cnt == 6'd1)) begin
                        cd_cnt_n = 6'd0;
                        state_n  = (ammo != 2'd0) ? READY : EMPTY;
                    end else if (new_frame) begin
                        cd_cnt_n = cd_cnt - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            trigger_q    <= 1'b0;
            hit_lock     <= 1'b0;
            cd_cnt       <= 6'd0;
            ammo         <= 2'd0;
            hits         <= 4'd0;
            score        <= 16'd0;
            shot_fired   <= 1'b0;
            duck_hit_evt <= 1'b0;
            round_over   <= 1'b0;
        end else begin
            state        <= state_n;
            trigger_q    <= trigger;
            hit_lock     <= hit_lock_n;
            cd_cnt       <= cd_cnt_n;
            ammo         <= ammo_n;
            hits         <= hits_n;
            score        <= score_n;
            shot_fired   <= shot_n;
            duck_hit_evt <= hit_evt_n;
            round_over   <= (state_n == EMPTY);
        end
    end

endmodule
